seq_divider_16by8: RTL and testbench
====================================

# seq_divider_16by8

Multi-cycle restoring integer divider. It accepts an unsigned 16-bit dividend and an 8-bit divisor over a valid/ready handshake, and returns a 16-bit quotient and an 8-bit remainder. It is the inverse of the combinational 8x8 Wallace multiplier: for any multiplier product p = a*b with b != 0, it returns quotient a and remainder 0. It produces one quotient bit per clock and sits behind the arithmetic datapath as a shared, non-pipelined resource.

## Interface
- DIVIDEND_W, default 16: dividend and quotient width; sets iteration count.
- DIVISOR_W, default 8: divisor and remainder width; must be <= DIVIDEND_W.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- in_valid, input, 1: dividend/divisor presented.
- in_ready, output, 1: block idle and can accept an operation.
- dividend, input, DIVIDEND_W: unsigned dividend, sampled on accept.
- divisor, input, DIVISOR_W: unsigned divisor, sampled on accept.
- out_valid, output, 1: result registers hold a completed result.
- out_ready, input, 1: consumer accepts the result.
- quotient, output, DIVIDEND_W: unsigned quotient.
- remainder, output, DIVISOR_W: unsigned remainder.
- div_by_zero, output, 1: the result belongs to an operation with divisor == 0.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept: in_valid && in_ready at a rising edge.
  - Latch dividend into a shift register and divisor into a register.
  - Clear the partial remainder (DIVISOR_W+1 bits) and the iteration counter.
  - divisor != 0: go to CALC.
  - divisor == 0: go to DONE directly with quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div_by_zero = 1.
- CALC step, one per clock, MSB of dividend first:
  - r' = {r[DIVISOR_W-1:0], next dividend bit}.
  - If r' >= {1'b0, divisor}: r = r' - divisor and the quotient bit is 1.
  - Otherwise r = r' and the quotient bit is 0.
  - The quotient bit shifts into the LSB of the quotient register.
  - The counter increments; after step DIVIDEND_W go to DONE.
- Result invariant: quotient*divisor + remainder == dividend, and remainder < divisor.
- The comparison must use DIVISOR_W+1 bits, because r' can exceed 2^DIVISOR_W - 1 (e.g. divisor 255).
- DONE:
  - quotient, remainder and div_by_zero are held stable while out_ready is low.
  - out_valid && out_ready: go to IDLE.
  - No same-cycle re-accept; in_ready rises the cycle after the result handshake.
- Inputs are ignored outside IDLE. in_valid held high while busy has no effect.
- quotient, remainder and div_by_zero are only meaningful while out_valid = 1; they keep their last value otherwise.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0.
  - Internal shift, remainder and counter registers = 0.
- Normal latency, with accept at edge E:
  - CALC iterations occur at edges E+1 .. E+16.
  - out_valid is high after edge E+16, i.e. 16 cycles after accept (DIVIDEND_W in general).
- Divide-by-zero latency: out_valid is high after edge E (1 cycle).
- Minimum throughput with out_ready held high: one operation per 18 cycles (accept, 16 CALC, 1 DONE).
- Reset asserted mid-CALC or in DONE: the operation is discarded with no partial output. The block is idle with in_ready = 1 on the first edge after rst_n deasserts.
- Inputs require no combinational path; every output is a register or a decode of state only.

## Test plan
- 150 / 10 -> quotient 15, remainder 0, div_by_zero 0; out_valid exactly 16 cycles after accept.
- 65025 / 255 -> quotient 255, remainder 0; 1000 / 7 -> quotient 142, remainder 6; 65535 / 1 -> quotient 65535, remainder 0; 5 / 200 -> quotient 0, remainder 5.
- 1234 / 0 -> out_valid 1 cycle after accept; quotient 16'hFFFF, remainder 8'hD2, div_by_zero 1; the next 150 / 10 returns div_by_zero 0.
- Backpressure: 1000 / 7 with out_ready low for 5 cycles after out_valid -> outputs stable and in_ready 0 throughout. Release out_ready -> in_ready 1 on the following cycle. Changes to in_valid/dividend while busy do not alter the result.
- Reset mid-operation: accept 40000 / 3, pull rst_n low at CALC iteration 8 -> all outputs at reset values immediately. After release, 40000 / 3 -> quotient 13333, remainder 1.
- Random: 200 pairs with divisor in 1..255 -> quotient*divisor + remainder == dividend and remainder < divisor. Also 200 products a*b with b != 0 -> quotient a, remainder 0.

Source files
------------

// File: rtl/seq_divider_16by8.sv
// ---------------------------------------------------------------------------
// seq_divider_16by8
//
// Multi-cycle restoring unsigned divider. One quotient bit is produced per
// clock, MSB of the dividend first. Shared, non-pipelined: a new operation is
// only accepted while idle, and the result is held until it is consumed.
// A zero divisor skips iteration and returns quotient = all ones,
// remainder = low DIVISOR_W bits of the dividend, div_by_zero = 1.
//
// Parameters
//   DIVIDEND_W  dividend / quotient width, also the iteration count
//   DIVISOR_W   divisor / remainder width (must be <= DIVIDEND_W)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     dividend/divisor presented
//   in_ready     idle, an operation can be accepted
//   dividend     unsigned dividend, sampled on accept
//   divisor      unsigned divisor, sampled on accept
//   out_valid    result registers hold a completed result
//   out_ready    consumer accepts the result
//   quotient     unsigned quotient
//   remainder    unsigned remainder
//   div_by_zero  result belongs to an operation with divisor == 0
// ---------------------------------------------------------------------------
module seq_divider_16by8 #(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;

    // Dividend shift register; quotient bits shift in at the LSB as dividend
    // bits leave at the MSB, so after the last step it holds the quotient.
    logic [DIVIDEND_W-1:0]   dvd_q;
    logic [DIVISOR_W-1:0]    dsr_q;
    // The restored partial remainder is always < divisor, so only the shifted
    // value r' needs the extra bit; it lives in the combinational step below.
    logic [DIVISOR_W-1:0]    rem_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [DIVIDEND_W-1:0]   quot_q;
    logic [DIVISOR_W-1:0]    rmd_q;
    logic                    dbz_q;

    // One restoring step
    logic [DIVISOR_W:0]      r_shift_d;
    logic [DIVISOR_W:0]      r_diff_d;
    logic                    q_bit_d;
    logic [DIVISOR_W-1:0]    rem_d;
    logic [DIVIDEND_W-1:0]   dvd_d;

    always_comb begin
        r_shift_d = {rem_q, dvd_q[DIVIDEND_W-1]};
        r_diff_d  = r_shift_d - {1'b0, dsr_q};
        // r' >= divisor evaluated on DIVISOR_W+1 bits: either r' has its top
        // bit set (so it exceeds any divisor), or the subtraction did not
        // borrow into bit DIVISOR_W.
        q_bit_d   = r_shift_d[DIVISOR_W] | ~r_diff_d[DIVISOR_W];
        rem_d     = q_bit_d ? r_diff_d[DIVISOR_W-1:0] : r_shift_d[DIVISOR_W-1:0];
        dvd_d     = {dvd_q[DIVIDEND_W-2:0], q_bit_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q <= dividend;
                        dsr_q <= divisor;
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (divisor == '0) begin
                            quot_q  <= '1;
                            rmd_q   <= dividend[DIVISOR_W-1:0];
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end

                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Result registers load only on the final step so they
                    // keep the previous result while iterating.
                    if (cnt_q == LAST_STEP) begin
                        quot_q  <= dvd_d;
                        rmd_q   <= rem_d;
                        dbz_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_16by8
//
// Scoreboard bench for seq_divider_16by8. The stimulus thread issues
// operations and pushes the expected result; a monitor pops and compares on
// every result handshake. Timing, backpressure and reset behaviour are
// checked inline by the stimulus thread.
// ---------------------------------------------------------------------------
module tb_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_divider_16by8 #(
        .DIVIDEND_W(16),
        .DIVISOR_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on each result handshake (sampled mid-cycle).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got q=%0d r=%0d z=%0d with empty scoreboard",
                             quotient, remainder, div_by_zero);
                end else begin
                    e = sb.pop_front();
                    check("quotient",    32'(quotient),    32'(e.q));
                    check("remainder",   32'(remainder),   32'(e.r));
                    check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                end
            end
        end
    end

    // All driving happens 1 time unit after a rising edge.
    // exp_edges: edges after the accept edge until out_valid is seen high.
    // hold: cycles to keep out_ready low once the result is presented, with
    // junk on in_valid/dividend/divisor while busy.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic ez,
                         input int exp_edges, input int hold);
        int   k;
        exp_t e;
        for (int i = 0; i < 100 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        e.q = eq; e.r = er; e.z = ez;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = (hold != 0);
        dividend = 16'(37 * a + 11);
        divisor  = 8'(b + 8'd3);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("accept_to_out_valid_edges", 32'(k), 32'(exp_edges));
        in_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            check("hold_quotient",  32'(quotient),    32'(eq));
            check("hold_remainder", 32'(remainder),   32'(er));
            check("hold_dbz",       32'(div_by_zero), 32'(ez));
            check("hold_out_valid", 32'(out_valid),   32'd1);
            check("hold_in_ready",  32'(in_ready),    32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a;
        int b;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_in_ready",  32'(in_ready),    32'd1);
        check("reset_out_valid", 32'(out_valid),   32'd0);
        check("reset_quotient",  32'(quotient),    32'd0);
        check("reset_remainder", 32'(remainder),   32'd0);
        check("reset_dbz",       32'(div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, expected values worked out by hand
        do_op(16'd150,   8'd10,  16'd15,    8'd0, 1'b0, 16, 0);
        do_op(16'd65025, 8'd255, 16'd255,   8'd0, 1'b0, 16, 0);
        do_op(16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 16, 0);
        do_op(16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, 16, 0);
        do_op(16'd5,     8'd200, 16'd0,     8'd5, 1'b0, 16, 0);
        do_op(16'd65535, 8'd255, 16'd257,   8'd0, 1'b0, 16, 0);
        do_op(16'd65534, 8'd255, 16'd256,   8'd254, 1'b0, 16, 0);
        do_op(16'd0,     8'd9,   16'd0,     8'd0, 1'b0, 16, 0);
        do_op(16'd1234,  8'd0,   16'hFFFF,  8'hD2, 1'b1, 0, 0);
        do_op(16'd150,   8'd10,  16'd15,    8'd0, 1'b0, 16, 0);
        do_op(16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 16, 5);
        do_op(16'd1234,  8'd0,   16'hFFFF,  8'hD2, 1'b1, 0, 0);

        // Reset during CALC: no result is expected from this operation
        in_valid = 1'b1;
        dividend = 16'd40000;
        divisor  = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_in_ready",  32'(in_ready),    32'd1);
        check("midreset_out_valid", 32'(out_valid),   32'd0);
        check("midreset_quotient",  32'(quotient),    32'd0);
        check("midreset_remainder", 32'(remainder),   32'd0);
        check("midreset_dbz",       32'(div_by_zero), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        do_op(16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0, 16, 0);

        // Random pairs: expectation from the bench's own integer arithmetic
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(1, 255));
            do_op(16'(a), 8'(b), 16'(a / b), 8'(a % b), 1'b0, 16, 0);
        end
        // Multiplier products divide back exactly
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            do_op(16'(a * b), 8'(b), 16'(a), 8'd0, 1'b0, 16, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
